mem_port_arbiter: RTL and testbench

Two-port arbiter and access sequencer that shares the single synchronous 512 x 32 main memory between the CPU memory path (MAR/MDR driven by the control unit during fetch, `ld` and `st`) and an external loader/debug port. Each access runs through a fixed four-state sequence with a registered request/acknowledge handshake per port. The control unit holds its T-state while `cpu_req` is high and `cpu_ack` is low.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous 512x32 memory between the CPU memory path and an external
// loader/debug port; every access runs the fixed sequence IDLE -> ACCESS -> CAPTURE -> DONE.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_EXT  = 2'b10;

  state_e            state_q, state_d;
  logic              last_ext_q, last_ext_d;
  logic              we_q, we_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              grant_cpu_c;
  logic              grant_ext_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  // A tie goes to the CPU under fixed priority, otherwise to the port not granted last.
  always_comb begin
    grant_cpu_c = cpu_req & (~ext_req | FIXED_PRIO | last_ext_q);
    grant_ext_c = ext_req & ~grant_cpu_c;
    sel_we_c    = grant_cpu_c ? cpu_we    : ext_we;
    sel_addr_c  = grant_cpu_c ? cpu_addr  : ext_addr;
    sel_wdata_c = grant_cpu_c ? cpu_wdata : ext_wdata;
  end

  always_comb begin
    state_d     = state_q;
    last_ext_d  = last_ext_q;
    we_d        = we_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu_c || grant_ext_c) begin
          state_d     = ACCESS;
          we_d        = sel_we_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_re_d    = ~sel_we_c;
          mem_we_d    = sel_we_c;
          owner_d     = grant_cpu_c ? OWN_CPU : OWN_EXT;
          last_ext_d  = grant_ext_c;
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      // Memory data is valid now; load it and raise the owner's ack for DONE.
      CAPTURE: begin
        state_d = DONE;
        if (!we_q) begin
          if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
          else                    ext_rdata_d = mem_rdata;
        end
        cpu_ack_d = (owner_q == OWN_CPU);
        ext_ack_d = (owner_q == OWN_EXT);
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_ext_q  <= 1'b1;
      we_q        <= 1'b0;
      owner_q     <= OWN_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_ext_q  <= last_ext_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own synchronous memory model; a queue holds the expected acks of the first.
module tb_mem_port_arbiter;

  logic        Clock;
  logic        reset;
  logic        mem_load;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [8:0]  cpu_addr, ext_addr;
  logic [31:0] cpu_wdata, ext_wdata;

  logic        d0_cpu_ack, d0_ext_ack, d0_mem_re, d0_mem_we;
  logic [31:0] d0_cpu_rdata, d0_ext_rdata, d0_mem_wdata, d0_mem_rdata;
  logic [8:0]  d0_mem_addr;
  logic [1:0]  d0_owner;
  logic        d1_cpu_ack, d1_ext_ack, d1_mem_re, d1_mem_we;
  logic [31:0] d1_cpu_rdata, d1_ext_rdata, d1_mem_wdata, d1_mem_rdata;
  logic [8:0]  d1_mem_addr;
  logic [1:0]  d1_owner;

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];

  typedef struct {
    bit          ext;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  bit   sb_en;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRIO(1'b0)) dut0 (
    .Clock(Clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(d0_cpu_ack), .cpu_rdata(d0_cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(d0_ext_ack), .ext_rdata(d0_ext_rdata),
    .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata), .mem_re(d0_mem_re),
    .mem_we(d0_mem_we), .mem_rdata(d0_mem_rdata), .owner(d0_owner)
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRIO(1'b1)) dut1 (
    .Clock(Clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(d1_cpu_ack), .cpu_rdata(d1_cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(d1_ext_ack), .ext_rdata(d1_ext_rdata),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_re(d1_mem_re),
    .mem_we(d1_mem_we), .mem_rdata(d1_mem_rdata), .owner(d1_owner)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous memories: read data appears the cycle after the read strobe.
  always @(posedge Clock) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= 32'h0;
        mem1[i] <= 32'h0;
      end
      mem0[5] <= 32'h1234ABCD;
      mem1[5] <= 32'h1234ABCD;
    end else begin
      if (d0_mem_we) mem0[d0_mem_addr] <= d0_mem_wdata;
      if (d1_mem_we) mem1[d1_mem_addr] <= d1_mem_wdata;
    end
    if (d0_mem_re) d0_mem_rdata <= mem0[d0_mem_addr];
    if (d1_mem_re) d1_mem_rdata <= mem1[d1_mem_addr];
  end

  // Scoreboard: each ack of the round-robin instance is matched to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #2;
      if (sb_en && (d0_cpu_ack || d0_ext_ack)) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_ack: got cpu_ack=%0b ext_ack=%0b required none", d0_cpu_ack, d0_ext_ack);
        end else begin
          e = sb_q.pop_front();
          if (d0_cpu_ack === e.ext || d0_ext_ack !== e.ext) begin
            errors++;
            $display("FAIL sb_ack_port: got cpu_ack=%0b ext_ack=%0b required ext=%0b", d0_cpu_ack, d0_ext_ack, e.ext);
          end else if (e.rd) begin
            if ((e.ext ? d0_ext_rdata : d0_cpu_rdata) !== e.data) begin
              errors++;
              $display("FAIL sb_rdata: got %h required %h", e.ext ? d0_ext_rdata : d0_cpu_rdata, e.data);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_d0_ack(input bit ext, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (ext ? d0_ext_ack : d0_cpu_ack) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_load = 1'b1;
    tick();
    tick();
    mem_load = 1'b0;
    checks += 10;
    if (d0_cpu_ack !== 1'b0)     begin errors++; $display("FAIL rst_cpu_ack: got %b required 0", d0_cpu_ack); end
    if (d0_ext_ack !== 1'b0)     begin errors++; $display("FAIL rst_ext_ack: got %b required 0", d0_ext_ack); end
    if (d0_mem_re !== 1'b0)      begin errors++; $display("FAIL rst_mem_re: got %b required 0", d0_mem_re); end
    if (d0_mem_we !== 1'b0)      begin errors++; $display("FAIL rst_mem_we: got %b required 0", d0_mem_we); end
    if (d0_mem_addr !== 9'h0)    begin errors++; $display("FAIL rst_mem_addr: got %h required 0", d0_mem_addr); end
    if (d0_mem_wdata !== 32'h0)  begin errors++; $display("FAIL rst_mem_wdata: got %h required 0", d0_mem_wdata); end
    if (d0_cpu_rdata !== 32'h0)  begin errors++; $display("FAIL rst_cpu_rdata: got %h required 0", d0_cpu_rdata); end
    if (d0_ext_rdata !== 32'h0)  begin errors++; $display("FAIL rst_ext_rdata: got %h required 0", d0_ext_rdata); end
    if (d0_owner !== 2'b00)      begin errors++; $display("FAIL rst_owner: got %b required 00", d0_owner); end
    if (d1_owner !== 2'b00)      begin errors++; $display("FAIL rst_owner_fixed: got %b required 00", d1_owner); end
    reset = 1'b0;
    tick();
    checks++;
    if (d0_owner !== 2'b00 || d0_mem_re !== 1'b0) begin
      errors++; $display("FAIL idle_after_rst: got owner=%b mem_re=%b required 00/0", d0_owner, d0_mem_re);
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005; cpu_wdata = 32'h0;
    sb_q.push_back('{ext: 1'b0, rd: 1'b1, data: 32'h1234ABCD});
    tick();
    checks += 3;
    if (d0_mem_re !== 1'b1 || d0_mem_we !== 1'b0) begin errors++; $display("FAIL rd_strobe: got re=%b we=%b required 1/0", d0_mem_re, d0_mem_we); end
    if (d0_mem_addr !== 9'h005) begin errors++; $display("FAIL rd_addr: got %h required 005", d0_mem_addr); end
    if (d0_owner !== 2'b01)     begin errors++; $display("FAIL rd_owner: got %b required 01", d0_owner); end
    tick();
    checks++;
    if (d0_mem_re !== 1'b0) begin errors++; $display("FAIL rd_strobe_len: got %b required 0", d0_mem_re); end
    tick();
    checks += 2;
    if (d0_cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_cycle3: got %b required 1", d0_cpu_ack); end
    if (d0_ext_ack !== 1'b0) begin errors++; $display("FAIL rd_ext_ack: got %b required 0", d0_ext_ack); end
    cpu_req = 1'b0;
    tick();
    tick();
    checks += 3;
    if (d0_cpu_ack !== 1'b0)          begin errors++; $display("FAIL rd_ack_pulse: got %b required 0", d0_cpu_ack); end
    if (d0_owner !== 2'b00)           begin errors++; $display("FAIL rd_owner_clr: got %b required 00", d0_owner); end
    if (d0_cpu_rdata !== 32'h1234ABCD) begin errors++; $display("FAIL rd_hold: got %h required 1234abcd", d0_cpu_rdata); end
  endtask

  task automatic test_ext_write_cpu_read();
    int  we_cycles;
    bit  seen;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h1FF; ext_wdata = 32'hDEADBEEF;
    sb_q.push_back('{ext: 1'b1, rd: 1'b0, data: 32'h0});
    we_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (d0_mem_we) begin
        we_cycles++;
        checks++;
        if (d0_mem_addr !== 9'h1FF || d0_mem_wdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL wr_bus: got %h/%h required 1ff/deadbeef", d0_mem_addr, d0_mem_wdata);
        end
      end
      if (d0_ext_ack) seen = 1'b1;
    end
    ext_req = 1'b0;
    checks += 3;
    if (!seen)               begin errors++; $display("FAIL wr_ack_timeout: got no ext_ack required ack"); end
    if (we_cycles != 1)      begin errors++; $display("FAIL wr_we_len: got %0d required 1", we_cycles); end
    if (d0_ext_rdata !== 32'h0) begin errors++; $display("FAIL wr_ext_rdata: got %h required 0", d0_ext_rdata); end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1FF;
    sb_q.push_back('{ext: 1'b0, rd: 1'b1, data: 32'hDEADBEEF});
    wait_d0_ack(1'b0, seen);
    cpu_req = 1'b0;
    checks += 2;
    if (!seen) begin errors++; $display("FAIL rdback_timeout: got no cpu_ack required ack"); end
    if (d0_ext_rdata !== 32'h0) begin errors++; $display("FAIL rdback_ext_rdata: got %h required 0", d0_ext_rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    int ack_cyc[$];
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h1FF;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{ext: 1'b0, rd: 1'b1, data: 32'h1234ABCD});
      sb_q.push_back('{ext: 1'b1, rd: 1'b1, data: 32'hDEADBEEF});
    end
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (d0_cpu_ack || d0_ext_ack) ack_cyc.push_back(c);
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    checks++;
    if (ack_cyc.size() != 4) begin
      errors++; $display("FAIL rr_ack_count: got %0d required 4", ack_cyc.size());
    end else begin
      checks++;
      if (ack_cyc[0] != 3) begin errors++; $display("FAIL rr_first_ack: got cycle %0d required 3", ack_cyc[0]); end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (ack_cyc[i] - ack_cyc[i-1] != 4) begin
          errors++; $display("FAIL rr_spacing: got %0d required 4", ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_fixed_prio();
    int  cpu_acks;
    int  ext_acks;
    bit  seen;
    bit  ext_owned;
    sb_en = 1'b0;
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h1FF;
    cpu_acks = 0; ext_acks = 0; ext_owned = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (d1_cpu_ack) cpu_acks++;
      if (d1_ext_ack) ext_acks++;
      if (d1_owner == 2'b10) ext_owned = 1'b1;
    end
    cpu_req = 1'b0;
    checks += 4;
    if (cpu_acks != 4)  begin errors++; $display("FAIL fp_cpu_acks: got %0d required 4", cpu_acks); end
    if (ext_acks != 0)  begin errors++; $display("FAIL fp_ext_acks: got %0d required 0", ext_acks); end
    if (ext_owned)      begin errors++; $display("FAIL fp_ext_owner: got ext granted required never"); end
    if (d1_cpu_rdata !== 32'h1234ABCD) begin errors++; $display("FAIL fp_cpu_rdata: got %h required 1234abcd", d1_cpu_rdata); end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (d1_ext_ack) seen = 1'b1;
    end
    ext_req = 1'b0;
    checks += 2;
    if (!seen) begin errors++; $display("FAIL fp_ext_timeout: got no ext_ack required ack"); end
    if (d1_ext_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fp_ext_rdata: got %h required deadbeef", d1_ext_rdata); end
    for (int i = 0; i < 4; i++) tick();
    sb_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    int acks;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hA5A5A5A5;
    tick();
    checks++;
    if (d0_mem_we !== 1'b1) begin errors++; $display("FAIL mid_we_high: got %b required 1", d0_mem_we); end
    #2;
    reset = 1'b1;
    #1;
    checks += 4;
    if (d0_mem_we !== 1'b0)    begin errors++; $display("FAIL mid_we_drop: got %b required 0", d0_mem_we); end
    if (d0_owner !== 2'b00)    begin errors++; $display("FAIL mid_owner: got %b required 00", d0_owner); end
    if (d0_mem_addr !== 9'h0 || d0_mem_wdata !== 32'h0) begin
      errors++; $display("FAIL mid_bus_clr: got %h/%h required 0/0", d0_mem_addr, d0_mem_wdata);
    end
    if (d0_cpu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata_clr: got %h required 0", d0_cpu_rdata); end
    cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (d0_cpu_ack || d0_ext_ack) acks++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d0_cpu_ack || d0_ext_ack) acks++;
    end
    checks += 2;
    if (acks != 0) begin errors++; $display("FAIL mid_no_ack: got %0d acks required 0", acks); end
    if (mem0[9'h010] !== 32'h0) begin errors++; $display("FAIL mid_no_write: got %h required 0", mem0[9'h010]); end
    cpu_req = 1'b1;
    sb_q.push_back('{ext: 1'b0, rd: 1'b0, data: 32'h0});
    wait_d0_ack(1'b0, seen);
    cpu_req = 1'b0;
    tick();
    checks += 2;
    if (!seen) begin errors++; $display("FAIL rereq_timeout: got no cpu_ack required ack"); end
    if (mem0[9'h010] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rereq_write: got %h required a5a5a5a5", mem0[9'h010]); end
  endtask

  task automatic test_withdraw_after_grant();
    int extra;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    sb_q.push_back('{ext: 1'b0, rd: 1'b1, data: 32'h1234ABCD});
    tick();
    tick();
    cpu_req = 1'b0;
    tick();
    checks++;
    if (d0_cpu_ack !== 1'b1) begin errors++; $display("FAIL wd_ack: got %b required 1", d0_cpu_ack); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (d0_mem_re || d0_mem_we || d0_cpu_ack) extra++;
    end
    checks += 2;
    if (extra != 0)         begin errors++; $display("FAIL wd_second_access: got %0d active cycles required 0", extra); end
    if (d0_owner !== 2'b00) begin errors++; $display("FAIL wd_owner: got %b required 00", d0_owner); end
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1; sb_en = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h0; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 9'h0; ext_wdata = 32'h0;
    test_reset();
    test_cpu_read();
    test_ext_write_cpu_read();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_write();
    test_withdraw_after_grant();
    tick();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
